// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared types and constants for the register-file scan controller
package scan_pkg;

  localparam int IDX_W          = 5;
  localparam int TIMER_W        = 8;
  localparam int DEF_NUM_REGS   = 32;
  localparam int DEF_DRAIN      = 4;
  localparam int DEF_SETTLE     = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SETTLE,
    ST_PRESENT,
    ST_DONE
  } scan_state_t;

endpackage

// File: rtl/regfile_scan_ctrl_if.sv
// rtl/regfile_scan_ctrl_if.sv - register dump beat stream (valid/ready)
interface regfile_scan_ctrl_if
  import scan_pkg::*;
  ();

  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic [31:0]      out_data;

  modport master (output out_valid, output out_index, output out_data, input out_ready);
  modport slave  (input out_valid, input out_index, input out_data, output out_ready);

endinterface

// File: rtl/scan_timer.sv
// rtl/scan_timer.sv - loadable down-counter; a load of N keeps expired low for N-1 cycles
module scan_timer
  import scan_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  output logic               expired
);

  logic [TIMER_W-1:0] count;

  // A load of 0 behaves like 1 so the owning state always lasts at least one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= (load_value == '0) ? '0 : load_value - 1'b1;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/regfile_scan_ctrl.sv
// rtl/regfile_scan_ctrl.sv - freezes the core and streams every register out; SCAN_CHECKSUM_EN adds a running sum
module regfile_scan_ctrl
  import scan_pkg::*;
#(
  parameter int NUM_REGS      = DEF_NUM_REGS,
  parameter int DRAIN_CYCLES  = DEF_DRAIN,
  parameter int SETTLE_CYCLES = DEF_SETTLE
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [IDX_W-1:0] cpu_rs1,
  output logic [IDX_W-1:0] regfile_rs1,
  input  logic [31:0]      regfile_dataA,
  input  logic             cpu_rwe,
  output logic             rwe_out,
  output logic             cpu_stall,
  output logic             busy,
  output logic             done,
  regfile_scan_ctrl_if.master out_bus,
  output logic [31:0]      checksum
);

  localparam logic [TIMER_W-1:0] DRAIN_LOAD  = TIMER_W'(DRAIN_CYCLES);
  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES);
  localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_REGS - 1);

  scan_state_t        state, state_nx;
  logic [IDX_W-1:0]   index;
  logic [IDX_W-1:0]   beat_index;
  logic [31:0]        beat_data;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_expired;
  logic               xfer;
  logic               scan_start;
  logic               owns_port;

  scan_timer u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .expired    (timer_expired)
  );

  assign xfer       = (state == ST_PRESENT) && out_bus.out_ready;
  assign scan_start = (state == ST_IDLE) && start && !abort;

  always_comb begin
    state_nx    = state;
    timer_load  = 1'b0;
    timer_value = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx    = ST_DRAIN;
          timer_load  = 1'b1;
          timer_value = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (timer_expired) begin
          state_nx    = ST_SETTLE;
          timer_load  = 1'b1;
          timer_value = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (timer_expired) state_nx = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (xfer) begin
          if (index == LAST_IDX) begin
            state_nx = ST_DONE;
          end else begin
            state_nx    = ST_SETTLE;
            timer_load  = 1'b1;
            timer_value = SETTLE_LOAD;
          end
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (abort) state_nx = ST_IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      index      <= '0;
      beat_index <= '0;
      beat_data  <= '0;
    end else begin
      state <= state_nx;
      if (scan_start) index <= '0;
      if ((state == ST_SETTLE) && timer_expired) begin
        beat_data  <= regfile_dataA;
        beat_index <= index;
      end
      if (xfer && (index != LAST_IDX)) index <= index + 1'b1;
    end
  end

  // Read port A and the write enable belong to the scanner only while it is reading.
  assign owns_port   = (state == ST_SETTLE) || (state == ST_PRESENT);
  assign regfile_rs1 = owns_port ? index : cpu_rs1;
  assign rwe_out     = owns_port ? 1'b0 : cpu_rwe;

  assign busy              = (state != ST_IDLE);
  assign cpu_stall         = busy;
  assign done              = (state == ST_DONE);
  assign out_bus.out_valid = (state == ST_PRESENT);
  assign out_bus.out_index = beat_index;
  assign out_bus.out_data  = beat_data;

`ifdef SCAN_CHECKSUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else if (scan_start) begin
      sum_q <= '0;
    end else if (xfer) begin
      sum_q <= sum_q + beat_data;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_regfile_scan_ctrl.sv
// tb/tb_regfile_scan_ctrl.sv - randomized scoreboard bench for regfile_scan_ctrl (SCAN_CHECKSUM_EN aware)
module tb_regfile_scan_ctrl;

  localparam int N = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  cpu_rs1 = '0;
  logic [4:0]  regfile_rs1;
  logic [31:0] regfile_dataA;
  logic        cpu_rwe = 1'b0;
  logic        rwe_out;
  logic        cpu_stall;
  logic        busy;
  logic        done;
  logic [31:0] checksum;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;

  logic [31:0] regs [N];
  logic [31:0] model [N];
  logic [36:0] exp_q [$];
  logic [31:0] sum_model = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  regfile_scan_ctrl_if bus ();

  regfile_scan_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .cpu_rs1       (cpu_rs1),
    .regfile_rs1   (regfile_rs1),
    .regfile_dataA (regfile_dataA),
    .cpu_rwe       (cpu_rwe),
    .rwe_out       (rwe_out),
    .cpu_stall     (cpu_stall),
    .busy          (busy),
    .done          (done),
    .out_bus       (bus),
    .checksum      (checksum)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (rwe_out) regs[wa] <= wd;
  assign regfile_dataA = regs[regfile_rs1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted beat must match the next expected register.
  always @(negedge clock) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {27'd0, bus.out_index}, 32'hFFFF_FFFF);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("beat_index", {27'd0, bus.out_index}, {27'd0, e[36:32]});
        check("beat_data", bus.out_data, e[31:0]);
        sum_model = sum_model + e[31:0];
      end
    end
  end

  function automatic logic [31:0] exp_checksum(input logic [31:0] s);
`ifdef SCAN_CHECKSUM_EN
    return s;
`else
    return 32'd0;
`endif
  endfunction

  task automatic preload();
    for (int i = 0; i < N; i++) begin
      @(posedge clock); #1;
      wa = 5'(i); wd = model[i]; cpu_rwe = 1'b1;
    end
    @(posedge clock); #1;
    cpu_rwe = 1'b0;
  endtask

  task automatic begin_scan(input bit expect_beats);
    if (expect_beats) for (int i = 0; i < N; i++) exp_q.push_back({5'(i), model[i]});
    @(posedge clock); #1;
    start = 1'b1;
    sum_model = '0;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic run_scan(input int hold_idx, input int abort_idx);
    int  hold = 0;
    bit  fin = 0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(negedge clock);
      if (done) begin
        fin = 1;
        @(posedge clock); #1;
        check("busy_after_done", busy, 0);
      end else begin
        @(posedge clock); #1;
        if (bus.out_valid && int'(bus.out_index) == abort_idx) begin
          bus.out_ready = 1'b0;
          start = 1'b1;
          @(posedge clock); #1;
          start = 1'b0;
          check("start_ignored_valid", bus.out_valid, 1);
          check("start_ignored_index", {27'd0, bus.out_index}, 32'(abort_idx));
          abort = 1'b1;
          @(posedge clock); #1;
          abort = 1'b0;
          check("abort_busy", busy, 0);
          check("abort_stall", cpu_stall, 0);
          check("abort_valid", bus.out_valid, 0);
          check("abort_rs1", {27'd0, regfile_rs1}, {27'd0, cpu_rs1});
          check("abort_remaining", 32'(exp_q.size()), 32'(N - abort_idx));
          exp_q.delete();
          for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("abort_no_done", done, 0);
          end
          fin = 1;
        end else if (bus.out_valid && int'(bus.out_index) == hold_idx && hold < 5) begin
          bus.out_ready = 1'b0;
          hold++;
          check("hold_index", {27'd0, bus.out_index}, 32'(hold_idx));
          check("hold_data", bus.out_data, model[hold_idx]);
        end else begin
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    end
    check("scan_finished", fin, 1);
    if (hold_idx >= 0) check("hold_cycles", hold, 5);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) model[i] = 32'(3 * i);
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", bus.out_valid, 0);
    reset = 1'b1;
    preload();

    // Reset asserted in the middle of a scan.
    begin_scan(0);
    repeat (2) @(posedge clock);
    #1;
    cpu_rs1 = 5'd9; wa = 5'd9; wd = model[9]; cpu_rwe = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_stall", cpu_stall, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_index", {27'd0, bus.out_index}, 0);
    check("mid_rst_data", bus.out_data, 0);
    check("mid_rst_checksum", checksum, 0);
    check("mid_rst_rs1", {27'd0, regfile_rs1}, 9);
    check("mid_rst_rwe", rwe_out, 1);
    @(posedge clock); #1;
    reset = 1'b1; cpu_rwe = 1'b0;

    // Full-speed scan with writeback traffic: cycle-exact timing model.
    bus.out_ready = 1'b1;
    cpu_rs1 = 5'($urandom_range(0, 31));
    wa = 5'd31; wd = model[31];
    begin_scan(1);
    cpu_rwe = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clock);
      check($sformatf("valid_c%0d", k), bus.out_valid, (k >= 6 && k <= 68 && k % 2 == 0) ? 1 : 0);
      check($sformatf("done_c%0d", k), done, (k == 69) ? 1 : 0);
      if (k <= 4) begin
        check("drain_rwe", rwe_out, 1);
        check("drain_rs1", {27'd0, regfile_rs1}, {27'd0, cpu_rs1});
        check("drain_stall", cpu_stall, 1);
      end else if (k <= 68) begin
        check("scan_rwe_gated", rwe_out, 0);
      end
      if (k == 70) check("busy_c70", busy, 0);
    end
    cpu_rwe = 1'b0;
    bus.out_ready = 1'b0;
    check("full_beats_left", 32'(exp_q.size()), 0);
`ifdef SCAN_CHECKSUM_EN
    check("full_checksum", checksum, 32'd1488);
`else
    check("full_checksum", checksum, 32'd0);
`endif

    // Random back-pressure with a 5-cycle stall on beat 7.
    begin_scan(1);
    run_scan(7, -1);
    check("bp_beats_left", 32'(exp_q.size()), 0);
    check("bp_checksum", checksum, exp_checksum(sum_model));

    // Abort while beat 10 is presented.
    cpu_rs1 = 5'($urandom_range(0, 31));
    begin_scan(1);
    run_scan(-1, 10);
    check("abort_checksum", checksum, exp_checksum(32'd135));

    // Random register contents, random back-pressure.
    for (int i = 0; i < N; i++) model[i] = $urandom;
    preload();
    cpu_rs1 = 5'($urandom_range(0, 31));
    begin_scan(1);
    run_scan(-1, -1);
    check("rand_beats_left", 32'(exp_q.size()), 0);
    check("rand_checksum", checksum, exp_checksum(sum_model));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_scan_ctrl.md
# regfile_scan_ctrl

Debug controller that freezes the processor, takes over register-file read port A, and streams all architectural registers out over a valid/ready interface. It sits between `processor`, `regfile` and any host-side consumer (bench or debug link), replacing ad-hoc read-port hijacking with a sequenced, back-pressurable register dump.

## Interface
Parameters:
- `NUM_REGS`, 32, registers scanned, indices 0..NUM_REGS-1.
- `DRAIN_CYCLES`, 4, stall cycles before the first read; lets in-flight writebacks retire.
- `SETTLE_CYCLES`, 1, cycles the read address is held before `regfile_dataA` is captured (≥1).

Ports:
- `clock`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low.
- `start`  in  1  scan request; sampled only in IDLE.
- `abort`  in  1  forces IDLE from any state.
- `cpu_rs1`  in  5  processor read-A address.
- `regfile_rs1`  out  5  read-A address to regfile.
- `regfile_dataA`  in  32  regfile read-A data.
- `cpu_rwe`  in  1  processor regfile write enable.
- `rwe_out`  out  1  gated write enable to regfile.
- `cpu_stall`  out  1  freezes processor while busy.
- `busy`  out  1  high outside IDLE.
- `done`  out  1  one-cycle pulse at scan completion.
- `out_valid`  out  1  beat valid.
- `out_ready`  in  1  consumer ready.
- `out_index`  out  5  register index of beat.
- `out_data`  out  32  register value of beat.
- `checksum`  out  32  running sum (see Configuration).

## Operation
- FSM states: IDLE, DRAIN, SETTLE, PRESENT, DONE.
- IDLE: `regfile_rs1 = cpu_rs1`, `rwe_out = cpu_rwe`. `start` → DRAIN, timer loaded DRAIN_CYCLES, index 0.
- DRAIN: `cpu_stall`=1, `rwe_out = cpu_rwe` (writebacks complete), `regfile_rs1 = cpu_rs1`. Timer expiry → SETTLE, timer loaded SETTLE_CYCLES.
- SETTLE: `regfile_rs1 = index`, `rwe_out`=0. Timer expiry → capture `regfile_dataA` into `out_data`, `out_index = index` → PRESENT.
- PRESENT: `out_valid`=1, `regfile_rs1 = index`, `rwe_out`=0; `out_data`/`out_index` stable until `out_valid && out_ready` at an edge. On transfer: index == NUM_REGS-1 → DONE, else index+1 → SETTLE.
- DONE: `done`=1 for one cycle, `busy`/`cpu_stall` still high; → IDLE.
- `start` outside IDLE ignored. `abort` has priority over all transitions: next state IDLE, no `done`; a beat transferring on the same edge counts as delivered.
- Index counter 5 bits, never wraps (terminates at NUM_REGS-1).

## Timing
- Reset: state IDLE; `busy`, `cpu_stall`, `done`, `out_valid`=0; `out_index`, `out_data`, `checksum`=0; `regfile_rs1`/`rwe_out` pass-through.
- `busy`/`cpu_stall` rise the cycle after the edge sampling `start`; fall the cycle after DONE.
- With `out_ready` tied high: beat k valid for exactly one cycle; `done` high in cycle DRAIN_CYCLES + NUM_REGS×(SETTLE_CYCLES+1) + 1 after the start edge (69 with defaults).
- Back-pressure adds cycles one-for-one; no beat is dropped or duplicated.
- `regfile_rs1` mux and `rwe_out` gating are combinational from state; all other outputs registered.
- Reset asserted mid-scan: immediate return to reset values, no `done`.

## Configuration
- `SCAN_CHECKSUM_EN` defined: `checksum` = 32-bit wrapping sum of `out_data` over completed transfers; cleared on scan start; held after DONE/abort until next start.
- Undefined: no adder/register; `checksum` tied to 0.

## Structure
- `scan_pkg`: state enum, default parameter constants, index width constant (5).
- Sub-module `scan_timer`: loadable down-counter with `expired` flag, shared by DRAIN and SETTLE.

## Test plan
- Reset asserted low mid-operation with `cpu_rs1`=9, `cpu_rwe`=1 → all registered outputs 0, `regfile_rs1`=9, `rwe_out`=1.
- Preload r_i = 3i, pulse `start`, `out_ready`=1 → 32 beats, `out_index` 0..31, `out_data` 3i (r0 = 0), `done` at cycle 69, `busy` low next cycle.
- Drop `out_ready` for 5 cycles while beat index 7 valid → `out_valid` held, `out_index`=7 and `out_data`=21 stable, no skip.
- `cpu_rwe`=1 throughout scan → `rwe_out`=1 during DRAIN, 0 in SETTLE/PRESENT; regfile contents unchanged afterward.
- `abort` while index 10 presented → IDLE next cycle, `busy`=0, no `done`, `regfile_rs1` returns to `cpu_rs1`; second `start` during busy ignored.
- With `SCAN_CHECKSUM_EN`, r_i = 3i full scan → `checksum`=1488; without it → `checksum`=0.
